lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 129 ++++++++++++
 tb/tb_lfsr_checker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Tracks a tap-4/3/2/0 shift-right LFSR stream: hunts, syncs, locks.
// Counts and flags prediction errors while locked.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [7:0]  expected,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  state_t      cur, nxt;
  logic [3:0]  run, run_n;
  logic [3:0]  bad, bad_n;
  logic [7:0]  exp_n;
  logic [15:0] cnt_n;
  logic        pulse_n;
  logic        inc;

  function automatic logic [7:0] step(input logic [7:0] x);
    if (x == 8'h00) return 8'h01;
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  always_comb begin
    nxt     = cur;
    run_n   = run;
    bad_n   = bad;
    exp_n   = expected;
    pulse_n = 1'b0;
    inc     = 1'b0;
    if (in_valid) begin
      unique case (cur)
        HUNT: begin
          if (in_data != 8'h00) begin
            exp_n = step(in_data);
            run_n = 4'd0;
            nxt   = SYNC;
          end
        end
        SYNC: begin
          if (in_data == expected) begin
            exp_n = step(expected);
            if (run + 4'd1 >= LOCK_C) begin
              run_n = 4'd0;
              nxt   = LOCKED;
            end else begin
              run_n = run + 4'd1;
            end
          end else if (in_data != 8'h00) begin
            exp_n = step(in_data);
            run_n = 4'd0;
          end else begin
            run_n = 4'd0;
            nxt   = HUNT;
          end
        end
        LOCKED: begin
          // Keep free-running prediction; a bad sample must not re-seed.
          exp_n = step(expected);
          if (in_data == expected) begin
            bad_n = 4'd0;
          end else begin
            pulse_n = 1'b1;
            inc     = 1'b1;
            if (bad + 4'd1 >= LOSS_C) begin
              bad_n = 4'd0;
              nxt   = HUNT;
            end else begin
              bad_n = bad + 4'd1;
            end
          end
        end
        default: begin
          nxt   = HUNT;
          run_n = 4'd0;
          bad_n = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_n = err_count;
    if (clr_cnt)
      cnt_n = 16'h0000;
    else if (inc && err_count != 16'hFFFF)
      cnt_n = err_count + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= HUNT;
      run       <= 4'd0;
      bad       <= 4'd0;
      expected  <= 8'h01;
      err_pulse <= 1'b0;
      err_count <= 16'h0000;
      locked    <= 1'b0;
    end else begin
      cur       <= nxt;
      run       <= run_n;
      bad       <= bad_n;
      expected  <= exp_n;
      err_pulse <= pulse_n;
      err_count <= cnt_n;
      locked    <= (nxt == LOCKED);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker; second instance covers counter saturation.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, clr_cnt;
  logic [7:0]  in_data;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [7:0]  expected;
  logic [1:0]  state;

  logic        b_valid, b_clr;
  logic [7:0]  b_data;
  logic        b_locked, b_pulse;
  logic [15:0] b_count;
  logic [7:0]  b_exp;
  logic [1:0]  b_state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .clr_cnt(clr_cnt), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count),
    .expected(expected), .state(state)
  );

  lfsr_checker #(.LOCK_CNT(1), .LOSS_CNT(15)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_valid), .in_data(b_data),
    .clr_cnt(b_clr), .locked(b_locked),
    .err_pulse(b_pulse), .err_count(b_count),
    .expected(b_exp), .state(b_state)
  );

  function automatic logic [7:0] lstep(input logic [7:0] x);
    if (x == 8'h00) return 8'h01;
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic c);
    @(negedge clk);
    in_valid = v; in_data = d; clr_cnt = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic bcyc(input logic v, input logic [7:0] d,
                      input logic c);
    @(negedge clk);
    b_valid = v; b_data = d; b_clr = c;
    @(posedge clk);
    #1;
    b_valid = 1'b0; b_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 0; in_data = 0; clr_cnt = 0;
    b_valid = 0; b_data = 0; b_clr = 0;
    #12;
    n_checks++;
    if (state !== 2'd0) begin
      $display("FAIL rst_state got %0d want 0", state); n_fail++;
    end
    n_checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0) begin
      $display("FAIL rst_flags got %b%b want 00", locked, err_pulse);
      n_fail++;
    end
    n_checks++;
    if (err_count !== 16'h0) begin
      $display("FAIL rst_cnt got %h want 0000", err_count); n_fail++;
    end
    n_checks++;
    if (expected !== 8'h01) begin
      $display("FAIL rst_exp got %h want 01", expected); n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_gaps;
    cyc(1, 8'h00, 0);
    n_checks++;
    if (state !== 2'd0 || expected !== 8'h01) begin
      $display("FAIL zero_ign got %0d/%h want 0/01", state, expected);
      n_fail++;
    end
    cyc(0, 8'h55, 0);
    cyc(0, 8'h33, 0);
    n_checks++;
    if (state !== 2'd0 || expected !== 8'h01) begin
      $display("FAIL gap_hunt got %0d/%h want 0/01", state, expected);
      n_fail++;
    end
    cyc(1, 8'h01, 0);
    n_checks++;
    if (state !== 2'd1 || expected !== 8'h80) begin
      $display("FAIL seed got %0d/%h want 1/80", state, expected);
      n_fail++;
    end
    cyc(0, 8'h80, 0);
    cyc(0, 8'h99, 0);
    n_checks++;
    if (state !== 2'd1 || expected !== 8'h80 || err_pulse !== 1'b0) begin
      $display("FAIL gap_sync got %0d/%h want 1/80", state, expected);
      n_fail++;
    end
  endtask

  task automatic test_lock;
    cyc(1, 8'h80, 0);
    cyc(1, 8'h40, 0);
    cyc(1, 8'h20, 0);
    n_checks++;
    if (locked !== 1'b0 || state !== 2'd1 || expected !== 8'h10) begin
      $display("FAIL prelock got %b/%0d/%h want 0/1/10",
               locked, state, expected);
      n_fail++;
    end
    cyc(1, 8'h10, 0);
    n_checks++;
    if (locked !== 1'b1 || state !== 2'd2 || expected !== 8'h88) begin
      $display("FAIL lock got %b/%0d/%h want 1/2/88",
               locked, state, expected);
      n_fail++;
    end
  endtask

  task automatic test_single_error;
    cyc(1, 8'h55, 0);
    n_checks++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1) begin
      $display("FAIL err1 got %b/%h want 1/0001", err_pulse, err_count);
      n_fail++;
    end
    n_checks++;
    if (expected !== 8'hC4 || locked !== 1'b1) begin
      $display("FAIL err1_exp got %h/%b want C4/1", expected, locked);
      n_fail++;
    end
    cyc(1, 8'hC4, 0);
    n_checks++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1) begin
      $display("FAIL err1_end got %b/%h want 0/0001", err_pulse, err_count);
      n_fail++;
    end
    n_checks++;
    if (expected !== 8'hE2 || locked !== 1'b1) begin
      $display("FAIL match_exp got %h/%b want E2/1", expected, locked);
      n_fail++;
    end
  endtask

  task automatic test_loss;
    cyc(1, 8'h00, 0);
    cyc(1, 8'h00, 0);
    n_checks++;
    if (locked !== 1'b1 || err_count !== 16'd3 || state !== 2'd2) begin
      $display("FAIL loss2 got %b/%h/%0d want 1/0003/2",
               locked, err_count, state);
      n_fail++;
    end
    cyc(1, 8'h00, 0);
    n_checks++;
    if (locked !== 1'b0 || state !== 2'd0) begin
      $display("FAIL loss3 got %b/%0d want 0/0", locked, state);
      n_fail++;
    end
    n_checks++;
    if (err_count !== 16'd4 || err_pulse !== 1'b1) begin
      $display("FAIL loss3_cnt got %h/%b want 0004/1", err_count, err_pulse);
      n_fail++;
    end
  endtask

  task automatic test_resync;
    cyc(1, 8'h01, 0);
    cyc(1, 8'h33, 0);
    n_checks++;
    if (state !== 2'd1 || expected !== 8'h19) begin
      $display("FAIL reseed got %0d/%h want 1/19", state, expected);
      n_fail++;
    end
    cyc(1, 8'h00, 0);
    n_checks++;
    if (state !== 2'd0 || err_count !== 16'd4) begin
      $display("FAIL sync_zero got %0d/%h want 0/0004", state, err_count);
      n_fail++;
    end
  endtask

  task automatic test_clear;
    cyc(1, 8'h01, 0);
    cyc(1, 8'h80, 0);
    cyc(1, 8'h40, 0);
    cyc(1, 8'h20, 0);
    cyc(1, 8'h10, 0);
    cyc(1, 8'h00, 1);
    n_checks++;
    if (err_count !== 16'd0 || err_pulse !== 1'b1) begin
      $display("FAIL clr got %h/%b want 0000/1", err_count, err_pulse);
      n_fail++;
    end
    n_checks++;
    if (locked !== 1'b1 || expected !== 8'hC4) begin
      $display("FAIL clr_lock got %b/%h want 1/C4", locked, expected);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_lock;
    cyc(1, 8'h07, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (locked !== 1'b0 || state !== 2'd0 || err_pulse !== 1'b0) begin
      $display("FAIL arst got %b/%0d/%b want 0/0/0",
               locked, state, err_pulse);
      n_fail++;
    end
    n_checks++;
    if (err_count !== 16'd0 || expected !== 8'h01) begin
      $display("FAIL arst_cnt got %h/%h want 0000/01", err_count, expected);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h01, 0);
    n_checks++;
    if (state !== 2'd1 || expected !== 8'h80 || locked !== 1'b0) begin
      $display("FAIL post_rst got %0d/%h want 1/80", state, expected);
      n_fail++;
    end
  endtask

  task automatic test_saturation;
    logic [7:0] e;
    int errs;
    int bad;
    bcyc(1, 8'h01, 0);
    bcyc(1, 8'h80, 0);
    n_checks++;
    if (b_locked !== 1'b1 || b_exp !== 8'h40) begin
      $display("FAIL b_lock got %b/%h want 1/40", b_locked, b_exp);
      n_fail++;
    end
    e = 8'h40;
    errs = 0;
    bad = 0;
    while (errs < 65535) begin
      if (bad == 14) begin
        bcyc(1, e, 0);
        bad = 0;
      end else begin
        bcyc(1, e ^ 8'hFF, 0);
        errs++;
        bad++;
      end
      e = lstep(e);
    end
    n_checks++;
    if (b_count !== 16'hFFFF || b_locked !== 1'b1) begin
      $display("FAIL sat_reach got %h/%b want FFFF/1", b_count, b_locked);
      n_fail++;
    end
    bcyc(1, e, 0);
    e = lstep(e);
    bcyc(1, e ^ 8'hFF, 0);
    e = lstep(e);
    n_checks++;
    if (b_count !== 16'hFFFF || b_pulse !== 1'b1) begin
      $display("FAIL sat_hold got %h/%b want FFFF/1", b_count, b_pulse);
      n_fail++;
    end
    bcyc(1, e ^ 8'hFF, 1);
    n_checks++;
    if (b_count !== 16'h0000 || b_pulse !== 1'b1) begin
      $display("FAIL sat_clr got %h/%b want 0000/1", b_count, b_pulse);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_gaps();
    test_lock();
    test_single_error();
    test_loss();
    test_resync();
    test_clear();
    test_reset_mid_lock();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
